// File: rtl/click_generator.sv
// Metronome click generator: timed LED/tone burst per beat with bar tracking.
// Define CLICK_ACCENT_EN to enable downbeat accent tone, o_downbeat and o_beat_index.
module click_generator #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int CLICK_MS  = 30,
  parameter int TONE_HZ   = 1000,
  parameter int ACCENT_HZ = 2000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_trigger,
  input  logic [3:0] i_beats_per_bar,
  input  logic       i_mute,
  output logic       o_buzzer,
  output logic       o_led_beat,
  output logic       o_downbeat,
  output logic [3:0] o_beat_index
);

  localparam int CLICK_CYC_RAW = CLK_HZ / 1000 * CLICK_MS;
  localparam int HP_TONE_RAW   = CLK_HZ / (2 * TONE_HZ);
  localparam int HP_ACC_RAW    = CLK_HZ / (2 * ACCENT_HZ);
  localparam int CLICK_CYC     = (CLICK_CYC_RAW < 1) ? 1 : CLICK_CYC_RAW;
  localparam int HP_TONE       = (HP_TONE_RAW < 1) ? 1 : HP_TONE_RAW;
  localparam int HP_ACC        = (HP_ACC_RAW < 1) ? 1 : HP_ACC_RAW;
  localparam int HP_MAX        = (HP_TONE > HP_ACC) ? HP_TONE : HP_ACC;
  localparam int DUR_W         = $clog2(CLICK_CYC + 1);
  localparam int HP_W          = $clog2(HP_MAX + 1);

  localparam logic [DUR_W-1:0] DUR_LOAD     = DUR_W'(CLICK_CYC - 1);
  localparam logic [DUR_W-1:0] DUR_ONE      = DUR_W'(1);
  localparam logic [HP_W-1:0]  HP_ONE       = HP_W'(1);
  localparam logic [HP_W-1:0]  HP_TONE_LAST = HP_W'(HP_TONE - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLICK = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic              buzzer_q, buzzer_d;
  logic [HP_W-1:0]   hp_last;

`ifdef CLICK_ACCENT_EN
  localparam logic [HP_W-1:0] HP_ACC_LAST = HP_W'(HP_ACC - 1);

  logic       downbeat_q, downbeat_d;
  logic [3:0] beat_idx_q, beat_idx_d;
  logic [3:0] next_idx_q, next_idx_d;
  logic [3:0] bar_len;

  assign bar_len = (i_beats_per_bar == 4'd0) ? 4'd1 : i_beats_per_bar;
  assign hp_last = (beat_idx_q == 4'd0) ? HP_ACC_LAST : HP_TONE_LAST;
`else
  logic unused_bpb;

  assign unused_bpb = ^i_beats_per_bar;
  assign hp_last    = HP_TONE_LAST;
`endif

  // A trigger always wins, including on the final click cycle, so retriggers never leave a gap.
  always_comb begin
    state_d  = state_q;
    dur_d    = dur_q;
    hp_d     = hp_q;
    buzzer_d = buzzer_q;
`ifdef CLICK_ACCENT_EN
    downbeat_d = downbeat_q;
    beat_idx_d = beat_idx_q;
    next_idx_d = next_idx_q;
`endif
    if (i_trigger) begin
      state_d  = CLICK;
      dur_d    = DUR_LOAD;
      hp_d     = '0;
      buzzer_d = 1'b1;
`ifdef CLICK_ACCENT_EN
      beat_idx_d = next_idx_q;
      downbeat_d = (next_idx_q == 4'd0);
      // Comparing in 5 bits lets an out-of-range index wrap after one emission.
      if (({1'b0, next_idx_q} + 5'd1) >= {1'b0, bar_len}) begin
        next_idx_d = 4'd0;
      end else begin
        next_idx_d = next_idx_q + 4'd1;
      end
`endif
    end else if (state_q == CLICK) begin
      if (dur_q == '0) begin
        state_d  = IDLE;
        hp_d     = '0;
        buzzer_d = 1'b0;
`ifdef CLICK_ACCENT_EN
        downbeat_d = 1'b0;
`endif
      end else begin
        dur_d = dur_q - DUR_ONE;
        if (hp_q == hp_last) begin
          hp_d     = '0;
          buzzer_d = ~buzzer_q;
        end else begin
          hp_d = hp_q + HP_ONE;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      dur_q    <= '0;
      hp_q     <= '0;
      buzzer_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dur_q    <= dur_d;
      hp_q     <= hp_d;
      buzzer_q <= buzzer_d;
    end
  end

`ifdef CLICK_ACCENT_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      downbeat_q <= 1'b0;
      beat_idx_q <= 4'd0;
      next_idx_q <= 4'd0;
    end else begin
      downbeat_q <= downbeat_d;
      beat_idx_q <= beat_idx_d;
      next_idx_q <= next_idx_d;
    end
  end

  assign o_downbeat   = downbeat_q;
  assign o_beat_index = beat_idx_q;
`else
  assign o_downbeat   = 1'b0;
  assign o_beat_index = 4'd0;
`endif

  // Mute gates only the audio path; timing state keeps running.
  assign o_buzzer   = buzzer_q & ~i_mute;
  assign o_led_beat = (state_q == CLICK);

endmodule

// File: tb/tb_click_generator.sv
// Directed self-checking bench for click_generator (10 kHz clock, 20-cycle clicks).
// Expectations follow CLICK_ACCENT_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_click_generator;

`ifdef CLICK_ACCENT_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif
  localparam int CYC = 20;
  localparam int HPT = 5;
  localparam int HPA = 2;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_trigger;
  logic [3:0] i_beats_per_bar;
  logic       i_mute;
  logic       o_buzzer;
  logic       o_led_beat;
  logic       o_downbeat;
  logic [3:0] o_beat_index;

  int checks = 0;
  int errors = 0;

  logic       led_h [0:63];
  logic       buz_h [0:63];
  logic       db_h  [0:63];
  logic [3:0] idx_h [0:63];

  click_generator #(
    .CLK_HZ   (10000),
    .CLICK_MS (2),
    .TONE_HZ  (1000),
    .ACCENT_HZ(2500)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_trigger      (i_trigger),
    .i_beats_per_bar(i_beats_per_bar),
    .i_mute         (i_mute),
    .o_buzzer       (o_buzzer),
    .o_led_beat     (o_led_beat),
    .o_downbeat     (o_downbeat),
    .o_beat_index   (o_beat_index)
  );

  always #5 i_clk = ~i_clk;

  function automatic int exp_hp(input int idx);
    return (ACC && idx == 0) ? HPA : HPT;
  endfunction

  function automatic logic [3:0] exp_idx(input int idx);
    return ACC ? 4'(idx) : 4'd0;
  endfunction

  function automatic int buz_errs(input int hp, input int n, input bit muted);
    int cnt = 0;
    logic e;
    for (int i = 0; i < n; i++) begin
      e = (!muted && i < CYC && ((i / hp) % 2 == 0)) ? 1'b1 : 1'b0;
      if (buz_h[i] !== e) cnt++;
    end
    return cnt;
  endfunction

  function automatic int db_errs(input logic v, input int n);
    int cnt = 0;
    logic e;
    for (int i = 0; i < n; i++) begin
      e = (i < CYC) ? v : 1'b0;
      if (db_h[i] !== e) cnt++;
    end
    return cnt;
  endfunction

  function automatic int led_errs(input int n);
    int cnt = 0;
    logic e;
    for (int i = 0; i < n; i++) begin
      e = (i < CYC) ? 1'b1 : 1'b0;
      if (led_h[i] !== e) cnt++;
    end
    return cnt;
  endfunction

  task automatic do_reset();
    i_trigger = 1'b0;
    i_reset   = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic fire();
    i_trigger = 1'b1;
    @(negedge i_clk);
    i_trigger = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      led_h[i] = o_led_beat;
      buz_h[i] = o_buzzer;
      db_h[i]  = o_downbeat;
      idx_h[i] = o_beat_index;
      @(negedge i_clk);
    end
  endtask

  task automatic test_reset();
    int e;
    i_mute          = 1'b0;
    i_beats_per_bar = 4'd4;
    i_trigger       = 1'b0;
    i_reset         = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    e = {28'd0, o_buzzer, o_led_beat, o_downbeat, 1'b0} | {28'd0, o_beat_index};
    checks++;
    if (e !== 0) begin
      errors++;
      $display("FAIL reset_outputs: got buz=%b led=%b db=%b idx=%0d want all 0",
               o_buzzer, o_led_beat, o_downbeat, o_beat_index);
    end
    i_reset = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_led_beat !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got led=%b want 0", o_led_beat);
    end
  endtask

  task automatic test_single_click();
    int e;
    do_reset();
    fire();
    capture(24);
    e = led_errs(24);
    checks++;
    if (e != 0) begin
      errors++;
      $display("FAIL single_led: got %0d bad cycles want 0", e);
    end
    e = db_errs(ACC, 24);
    checks++;
    if (e != 0) begin
      errors++;
      $display("FAIL single_downbeat: got %0d bad cycles want 0", e);
    end
    e = buz_errs(exp_hp(0), 24, 1'b0);
    checks++;
    if (e != 0) begin
      errors++;
      $display("FAIL single_buzzer: got %0d bad cycles want 0", e);
    end
    checks++;
    if (idx_h[0] !== 4'd0) begin
      errors++;
      $display("FAIL single_index: got %0d want 0", idx_h[0]);
    end
  endtask

  task automatic test_bar_sequence();
    int seq [4] = '{0, 1, 2, 0};
    int e;
    do_reset();
    i_beats_per_bar = 4'd3;
    for (int k = 0; k < 4; k++) begin
      fire();
      capture(39);
      checks++;
      if (idx_h[0] !== exp_idx(seq[k])) begin
        errors++;
        $display("FAIL bar_index%0d: got %0d want %0d", k, idx_h[0], exp_idx(seq[k]));
      end
      e = buz_errs(exp_hp(seq[k]), 39, 1'b0);
      checks++;
      if (e != 0) begin
        errors++;
        $display("FAIL bar_buzzer%0d: got %0d bad cycles want 0", k, e);
      end
      e = db_errs(ACC && seq[k] == 0, 39);
      checks++;
      if (e != 0) begin
        errors++;
        $display("FAIL bar_downbeat%0d: got %0d bad cycles want 0", k, e);
      end
    end
  endtask

  task automatic test_retrigger();
    int e;
    do_reset();
    i_beats_per_bar = 4'd4;
    fire();
    capture(10);
    fire();
    capture(24);
    e = led_errs(24);
    checks++;
    if (e != 0) begin
      errors++;
      $display("FAIL retrig_led: got %0d bad cycles want 0", e);
    end
    checks++;
    if (idx_h[0] !== exp_idx(1)) begin
      errors++;
      $display("FAIL retrig_index: got %0d want %0d", idx_h[0], exp_idx(1));
    end
    e = buz_errs(exp_hp(1), 24, 1'b0);
    checks++;
    if (e != 0) begin
      errors++;
      $display("FAIL retrig_buzzer: got %0d bad cycles want 0", e);
    end
    e = db_errs(1'b0, 24);
    checks++;
    if (e != 0) begin
      errors++;
      $display("FAIL retrig_downbeat: got %0d bad cycles want 0", e);
    end
    // Trigger lands on the final click cycle: click must continue without a gap.
    fire();
    capture(19);
    fire();
    capture(24);
    e = led_errs(24);
    checks++;
    if (e != 0) begin
      errors++;
      $display("FAIL lastcycle_led: got %0d bad cycles want 0", e);
    end
    checks++;
    if (idx_h[0] !== exp_idx(3)) begin
      errors++;
      $display("FAIL lastcycle_index: got %0d want %0d", idx_h[0], exp_idx(3));
    end
  endtask

  task automatic test_bar_shrink();
    do_reset();
    i_beats_per_bar = 4'd4;
    for (int k = 0; k < 3; k++) begin
      fire();
      capture(25);
    end
    i_beats_per_bar = 4'd2;
    fire();
    capture(25);
    checks++;
    if (idx_h[0] !== exp_idx(3)) begin
      errors++;
      $display("FAIL shrink_emit: got %0d want %0d", idx_h[0], exp_idx(3));
    end
    fire();
    capture(25);
    checks++;
    if (idx_h[0] !== 4'd0 || db_h[0] !== ACC) begin
      errors++;
      $display("FAIL shrink_wrap: got idx=%0d db=%b want idx=0 db=%b", idx_h[0], db_h[0], ACC);
    end
  endtask

  task automatic test_mute();
    int e;
    do_reset();
    i_beats_per_bar = 4'd4;
    i_mute = 1'b1;
    for (int k = 0; k < 2; k++) begin
      fire();
      capture(24);
      e = buz_errs(HPT, 24, 1'b1);
      checks++;
      if (e != 0) begin
        errors++;
        $display("FAIL mute_buzzer%0d: got %0d bad cycles want 0", k, e);
      end
      e = led_errs(24);
      checks++;
      if (e != 0) begin
        errors++;
        $display("FAIL mute_led%0d: got %0d bad cycles want 0", k, e);
      end
      checks++;
      if (idx_h[0] !== exp_idx(k)) begin
        errors++;
        $display("FAIL mute_index%0d: got %0d want %0d", k, idx_h[0], exp_idx(k));
      end
    end
    fire();
    capture(3);
    i_mute = 1'b0;
    #1;
    checks++;
    if (o_buzzer !== 1'b1) begin
      errors++;
      $display("FAIL unmute_buzzer: got %b want 1", o_buzzer);
    end
    @(negedge i_clk);
    capture(25);
  endtask

  task automatic test_reset_mid();
    int e;
    do_reset();
    i_beats_per_bar = 4'd4;
    fire();
    capture(7);
    i_reset = 1'b1;
    #1;
    checks++;
    if (o_buzzer !== 1'b0 || o_led_beat !== 1'b0 || o_downbeat !== 1'b0 || o_beat_index !== 4'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got buz=%b led=%b db=%b idx=%0d want all 0",
               o_buzzer, o_led_beat, o_downbeat, o_beat_index);
    end
    @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    fire();
    fire();
    capture(24);
    e = buz_errs(exp_hp(1), 24, 1'b0);
    checks++;
    if (idx_h[0] !== exp_idx(1) || e != 0) begin
      errors++;
      $display("FAIL midreset_second: got idx=%0d buzerr=%0d want idx=%0d buzerr=0",
               idx_h[0], e, exp_idx(1));
    end
    do_reset();
    fire();
    capture(24);
    e = buz_errs(exp_hp(0), 24, 1'b0);
    checks++;
    if (idx_h[0] !== 4'd0 || e != 0 || db_h[0] !== ACC) begin
      errors++;
      $display("FAIL midreset_first: got idx=%0d db=%b buzerr=%0d want idx=0 db=%b buzerr=0",
               idx_h[0], db_h[0], e, ACC);
    end
  endtask

  task automatic test_bpb_zero();
    int e;
    do_reset();
    i_beats_per_bar = 4'd0;
    for (int k = 0; k < 3; k++) begin
      fire();
      capture(24);
      e = buz_errs(exp_hp(0), 24, 1'b0);
      checks++;
      if (idx_h[0] !== 4'd0 || e != 0) begin
        errors++;
        $display("FAIL zero_bar%0d: got idx=%0d buzerr=%0d want idx=0 buzerr=0", k, idx_h[0], e);
      end
      e = db_errs(ACC, 24);
      checks++;
      if (e != 0) begin
        errors++;
        $display("FAIL zero_downbeat%0d: got %0d bad cycles want 0", k, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_click();
    test_bar_sequence();
    test_retrigger();
    test_bar_shrink();
    test_mute();
    test_reset_mid();
    test_bpb_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
